// File: rtl/vigenere_stream_cipher_if.sv
// Character stream bundle between the mod26 decoder, the cipher engine and the encoder.
// The master side feeds characters in and drains results; the slave side is the engine.
interface vigenere_stream_cipher_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;

  modport master (
    output in_valid, in_char, mode, out_ready,
    input  in_ready, out_valid, out_char
  );

  modport slave (
    input  in_valid, in_char, mode, out_ready,
    output in_ready, out_valid, out_char
  );
endinterface

// File: rtl/vigenere_stream_cipher.sv
// Streaming Vigenere encrypt/decrypt on mod26 codes with a loadable key of up to KEY_MAX letters.
// One character per cycle, registered output, spaces and non-letters pass as space without using a key slot.
module vigenere_stream_cipher #(
  parameter int KEY_MAX = 6
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           key_load,
  input  logic                           key_valid,
  input  logic [7:0]                     key_char,
  input  logic                           key_done,
  input  logic                           msg_start,
  vigenere_stream_cipher_if.slave        stream,
  output logic [$clog2(KEY_MAX+1)-1:0]   key_len,
  output logic                           key_ok
);
  localparam int LEN_W = $clog2(KEY_MAX + 1);
  localparam int SLOTS = 1 << LEN_W;

  typedef enum logic [1:0] {NOKEY, LOAD, RUN} state_t;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   key_len_reg;
  logic [LEN_W-1:0]   idx_reg;
  logic [4:0]         key_reg [SLOTS];
  logic               out_valid_reg;
  logic [7:0]         out_char_reg;

  logic               key_store;
  logic               in_ready_int;
  logic               accept;
  logic               in_is_letter;
  logic [4:0]         k_cur;
  logic [4:0]         c_cur;
  logic [5:0]         sum;
  logic [5:0]         diff;
  logic [7:0]         result;
  logic [LEN_W-1:0]   idx_next;

  assign key_store    = (state_reg == LOAD) && key_valid && !key_load &&
                        (key_char < 8'd26) && (key_len_reg < LEN_W'(KEY_MAX));
  assign in_ready_int = (state_reg == RUN) && (!out_valid_reg || stream.out_ready) && !key_load;
  assign accept       = stream.in_valid && in_ready_int;
  assign in_is_letter = (stream.in_char < 8'd26);

  assign k_cur = key_reg[idx_reg];
  assign c_cur = stream.in_char[4:0];
  assign sum   = {1'b0, c_cur} + {1'b0, k_cur};
  assign diff  = {1'b0, c_cur} - {1'b0, k_cur};

  // Operands are both below 26, so one conditional correction brings the result back into range.
  always_comb begin
    result = 8'd32;
    if (in_is_letter) begin
      if (!stream.mode) begin
        result = {2'b00, (sum >= 6'd26) ? (sum - 6'd26) : sum};
      end else begin
        result = {2'b00, diff[5] ? (diff + 6'd26) : diff};
      end
    end
  end

  assign idx_next = (idx_reg == key_len_reg - LEN_W'(1)) ? '0 : idx_reg + LEN_W'(1);

  always_comb begin
    state_next = state_reg;
    if (key_load) begin
      state_next = LOAD;
    end else if ((state_reg == LOAD) && key_done) begin
      // A character stored in the same cycle as key_done counts toward a usable key.
      state_next = ((key_len_reg != '0) || key_store) ? RUN : NOKEY;
    end
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_key
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          key_reg[gi] <= 5'd0;
        end else if (key_store && (key_len_reg == LEN_W'(gi))) begin
          key_reg[gi] <= key_char[4:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= NOKEY;
      key_len_reg   <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_char_reg  <= 8'd32;
    end else begin
      state_reg <= state_next;
      if (key_load) begin
        key_len_reg   <= '0;
        idx_reg       <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        if (key_store) begin
          key_len_reg <= key_len_reg + LEN_W'(1);
        end
        if (accept) begin
          out_valid_reg <= 1'b1;
          out_char_reg  <= result;
        end else if (stream.out_ready) begin
          out_valid_reg <= 1'b0;
        end
        if (msg_start) begin
          idx_reg <= '0;
        end else if (accept && in_is_letter) begin
          idx_reg <= idx_next;
        end
      end
    end
  end

  assign stream.in_ready  = in_ready_int;
  assign stream.out_valid = out_valid_reg;
  assign stream.out_char  = out_char_reg;
  assign key_len          = key_len_reg;
  assign key_ok           = (state_reg == RUN);
endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Bench for vigenere_stream_cipher: known-answer tables, hand-written corner sequences,
// and a randomized run against a modular-arithmetic reference model.
module tb_vigenere_stream_cipher;
  logic       clk = 1'b0;
  logic       resetn;
  logic       key_load, key_valid, key_done, msg_start;
  logic [7:0] key_char;
  logic [2:0] key_len;
  logic       key_ok;

  vigenere_stream_cipher_if sif ();

  vigenere_stream_cipher #(.KEY_MAX(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_load  (key_load),
    .key_valid (key_valid),
    .key_char  (key_char),
    .key_done  (key_done),
    .msg_start (msg_start),
    .stream    (sif.slave),
    .key_len   (key_len),
    .key_ok    (key_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in_char;
    logic       mode;
    logic [7:0] exp_char;
  } vec_t;

  vec_t tbl [29];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] ch [8], input int n);
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_char  = ch[i];
      step();
    end
    key_valid = 1'b0;
    key_done  = 1'b1;
    step();
    key_done  = 1'b0;
  endtask

  task automatic push(input string name, input logic [7:0] c, input logic m, input int exp);
    sif.in_valid = 1'b1;
    sif.in_char  = c;
    sif.mode     = m;
    #2;
    chk({name, "_ready"}, sif.in_ready, 1);
    step();
    chk({name, "_valid"}, sif.out_valid, 1);
    chk({name, "_char"}, sif.out_char, exp);
    $display("%s in=%0d mode=%0d out=%0d", name, c, m, sif.out_char);
    sif.in_valid = 1'b0;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sif.in_valid = 1'b1;
      sif.in_char  = tbl[i].in_char;
      sif.mode     = tbl[i].mode;
      #2;
      chk("tbl_ready", sif.in_ready, 1);
      step();
      chk("tbl_valid", sif.out_valid, 1);
      chk("tbl_char", sif.out_char, tbl[i].exp_char);
      $display("vec %0d in=%0d mode=%0d out=%0d", i, tbl[i].in_char, tbl[i].mode, sif.out_char);
    end
    sif.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] lemon [8];
    logic [7:0] kab   [8];
    logic [7:0] k7    [8];
    logic [7:0] knl   [8];
    logic [7:0] krnd  [8];
    int pt [12];
    int ct [12];
    int ab_in [5];
    int ab_out [5];
    int key_q [$];
    int mv, mc, midx, nraw;

    lemon = '{8'd11, 8'd4, 8'd12, 8'd14, 8'd13, 8'd0, 8'd0, 8'd0};
    kab   = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    k7    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0};
    knl   = '{8'd3, 8'd40, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pt     = '{0, 19, 19, 0, 2, 10, 0, 19, 3, 0, 22, 13};
    ct     = '{11, 23, 5, 14, 15, 21, 4, 5, 17, 13, 7, 17};
    ab_in  = '{1, 32, 1, 40, 1};
    ab_out = '{1, 32, 2, 32, 1};
    for (int i = 0; i < 12; i++) begin
      tbl[i]      = '{in_char: 8'(pt[i]), mode: 1'b0, exp_char: 8'(ct[i])};
      tbl[12 + i] = '{in_char: 8'(ct[i]), mode: 1'b1, exp_char: 8'(pt[i])};
    end
    for (int i = 0; i < 5; i++) begin
      tbl[24 + i] = '{in_char: 8'(ab_in[i]), mode: 1'b0, exp_char: 8'(ab_out[i])};
    end

    resetn = 1'b0;
    key_load = 1'b0; key_valid = 1'b0; key_done = 1'b0; msg_start = 1'b0; key_char = 8'd0;
    sif.in_valid = 1'b0; sif.in_char = 8'd0; sif.mode = 1'b0; sif.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", sif.in_ready, 0);
    chk("rst_out_valid", sif.out_valid, 0);
    chk("rst_out_char", sif.out_char, 32);
    chk("rst_key_len", key_len, 0);
    chk("rst_key_ok", key_ok, 0);
    resetn = 1'b1;
    step();

    // Known-answer: lemon encrypt, restart, decrypt; then key "ab" with spaces/invalid codes
    load_key(lemon, 5);
    chk("lemon_key_ok", key_ok, 1);
    chk("lemon_key_len", key_len, 5);
    run_table(0, 11);
    msg_start = 1'b1;
    step();
    msg_start = 1'b0;
    run_table(12, 23);
    load_key(kab, 2);
    run_table(24, 28);

    // Backpressure: first output held for three cycles
    load_key(lemon, 5);
    push("bp0", 8'd0, 1'b0, 11);
    sif.out_ready = 1'b0;
    sif.in_valid  = 1'b1;
    sif.in_char   = 8'd19;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_stall_ready", sif.in_ready, 0);
      step();
      chk("bp_stall_valid", sif.out_valid, 1);
      chk("bp_stall_char", sif.out_char, 11);
    end
    sif.out_ready = 1'b1;
    push("bp1", 8'd19, 1'b0, 23);
    push("bp2", 8'd19, 1'b0, 5);
    step();
    chk("bp_drain_valid", sif.out_valid, 0);

    // msg_start with a simultaneous accept uses the old index, then restarts
    load_key(lemon, 5);
    push("ms0", 8'd0, 1'b0, 11);
    push("ms1", 8'd0, 1'b0, 4);
    msg_start = 1'b1;
    push("ms2", 8'd0, 1'b0, 12);
    msg_start = 1'b0;
    push("ms3", 8'd0, 1'b0, 11);

    // Seven letters offered: the seventh is dropped
    load_key(k7, 7);
    chk("k7_len", key_len, 6);
    for (int i = 0; i < 7; i++) push("k7", 8'd0, 1'b0, (i < 6) ? i + 1 : 1);

    // Non-letter key character is skipped
    load_key(knl, 3);
    chk("knl_len", key_len, 2);
    push("knl0", 8'd0, 1'b0, 3);
    push("knl1", 8'd0, 1'b0, 5);
    push("knl2", 8'd0, 1'b0, 3);

    // Empty key returns to NOKEY
    load_key(knl, 0);
    chk("empty_key_ok", key_ok, 0);
    chk("empty_key_len", key_len, 0);
    sif.in_valid = 1'b1;
    #2;
    chk("empty_in_ready", sif.in_ready, 0);
    sif.in_valid = 1'b0;

    // key_valid together with key_done stores the char before leaving LOAD
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    key_valid = 1'b1; key_char = 8'd7; key_done = 1'b1;
    step();
    key_valid = 1'b0; key_done = 1'b0;
    chk("kd_key_ok", key_ok, 1);
    chk("kd_key_len", key_len, 1);
    push("kd0", 8'd1, 1'b0, 8);

    // key_load while an output is pending discards it
    load_key(lemon, 5);
    sif.out_ready = 1'b0;
    push("kl0", 8'd0, 1'b0, 11);
    sif.in_valid = 1'b1;
    key_load = 1'b1;
    #2;
    chk("kl_in_ready", sif.in_ready, 0);
    step();
    key_load = 1'b0;
    sif.in_valid = 1'b0;
    chk("kl_out_valid", sif.out_valid, 0);
    chk("kl_key_ok", key_ok, 0);
    chk("kl_key_len", key_len, 0);
    chk("kl_load_ready", sif.in_ready, 0);
    sif.out_ready = 1'b1;

    // Asynchronous reset while an output is pending
    load_key(lemon, 5);
    sif.out_ready = 1'b0;
    push("ar0", 8'd0, 1'b0, 11);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_out_valid", sif.out_valid, 0);
    chk("ar_out_char", sif.out_char, 32);
    chk("ar_key_len", key_len, 0);
    chk("ar_key_ok", key_ok, 0);
    chk("ar_in_ready", sif.in_ready, 0);
    resetn = 1'b1;
    sif.out_ready = 1'b1;
    step();

    // Randomized traffic against a reference model
    for (int r = 0; r < 3; r++) begin
      key_q.delete();
      nraw = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) begin
        if (i == 0 || ($urandom % 4) != 0) krnd[i] = 8'($urandom_range(0, 25));
        else krnd[i] = 8'($urandom_range(26, 255));
        if (i < nraw && krnd[i] < 26 && key_q.size() < 6) key_q.push_back(int'(krnd[i]));
      end
      load_key(krnd, nraw);
      chk("rnd_key_len", key_len, key_q.size());
      mv = 0; mc = 32; midx = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        int c, res, pred_ready;
        logic ordy, md, msg, iv;
        iv   = (($urandom % 4) != 0);
        ordy = (($urandom % 4) != 0);
        md   = 1'($urandom % 2);
        msg  = (($urandom % 16) == 0);
        case ($urandom % 10)
          7:       c = 32;
          8, 9:    c = $urandom_range(26, 255);
          default: c = $urandom_range(0, 25);
        endcase
        sif.in_valid = iv; sif.in_char = 8'(c); sif.mode = md;
        sif.out_ready = ordy; msg_start = msg;
        #2;
        pred_ready = (mv == 0 || ordy) ? 1 : 0;
        chk("rnd_in_ready", sif.in_ready, pred_ready);
        if (iv && pred_ready == 1) begin
          if (c < 26) begin
            res  = md ? (c - key_q[midx] + 26) % 26 : (c + key_q[midx]) % 26;
            midx = (midx + 1) % key_q.size();
          end else begin
            res = 32;
          end
          mv = 1; mc = res;
          $display("rnd %0d in=%0d mode=%0d exp=%0d", cyc, c, md, res);
        end else if (ordy) begin
          mv = 0;
        end
        if (msg) midx = 0;
        step();
        chk("rnd_out_valid", sif.out_valid, mv);
        if (mv == 1) chk("rnd_out_char", sif.out_char, mc);
      end
      sif.in_valid = 1'b0; msg_start = 1'b0; sif.out_ready = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vigenere_stream_cipher.md
# vigenere_stream_cipher

Streaming Vigenère encrypt/decrypt engine operating on mod26 character codes (0=a … 25=z, 32=space). It sits between the ASCII→mod26 decoder (upstream) and the mod26→ASCII encoder (downstream). It holds a key of up to KEY_MAX letters loaded one character at a time, and processes one character per cycle over a valid/ready handshake. Spaces pass through unchanged without consuming a key position.

## Interface
- KEY_MAX, 6: maximum key length in characters; 48-bit key = 6 chars.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- key_load  in  1  pulse: clear key, enter key entry.
- key_valid  in  1  key_char valid this cycle (LOAD state only).
- key_char  in  8  key character, mod26 code.
- key_done  in  1  pulse: finish key entry.
- msg_start  in  1  pulse: reset key index to 0; key is kept.
- mode  in  1  0=encrypt, 1=decrypt; sampled per accepted character.
- in_valid  in  1  upstream character valid.
- in_ready  out  1  engine can accept in_char.
- in_char  in  8  mod26 code from upstream.
- out_valid  out  1  out_char valid.
- out_ready  in  1  downstream accepts out_char.
- out_char  out  8  result, mod26 code (0..25 or 32).
- key_len  out  3  number of stored key characters (0..KEY_MAX).
- key_ok  out  1  1 in RUN state (usable key loaded).

## Operation
- FSM states: NOKEY (reset state), LOAD, RUN.
  - NOKEY→LOAD on key_load.
  - LOAD→RUN on key_done with key_len>0.
  - LOAD→NOKEY on key_done with key_len=0.
  - RUN→LOAD on key_load.
- key_load (any state): key_len←0, key index←0, out_valid←0. Any pending output is discarded.
- LOAD: key_valid with key_char in 0..25 and key_len<KEY_MAX stores the char at position key_len and increments key_len.
  - Non-letter key_char is ignored.
  - Chars beyond KEY_MAX are dropped.
  - key_valid and key_done in the same cycle: the char is stored first, then the FSM transitions.
- in_ready = RUN && (!out_valid || out_ready). It is 0 in NOKEY and LOAD.
- Accept = in_valid && in_ready. On accept, with k = key[idx]:
  - in_char 0..25, encrypt: s = in_char+k; out = s≥26 ? s−26 : s.
  - in_char 0..25, decrypt: d = in_char−k; out = d<0 ? d+26 : d.
  - 5-bit operands, 6-bit intermediate.
  - Letters advance idx: idx = (idx==key_len−1) ? 0 : idx+1.
  - in_char==32: out=32, idx unchanged.
  - Any other value: out=32, idx unchanged.
- msg_start: idx←0. It has no effect on key, key_len, FSM state or the output register.
  - msg_start and accept in the same cycle: the accepted char uses the pre-reset idx, and idx ends at 0.
- key_load takes priority over a simultaneous accept or msg_start. In that cycle in_ready is 0.

## Timing
- Reset values: state=NOKEY, key_len=0, idx=0, key regs=0, out_valid=0, out_char=32, in_ready=0, key_ok=0.
- Latency: 1 cycle. A character accepted at edge N appears on out_char with out_valid=1 after edge N.
- Throughput: 1 char/cycle while out_ready=1.
- Output is registered. out_char is stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new char is accepted in the same cycle (simultaneous pop/push).
- key_ok and key_len are registered and update the cycle after the causing event.
- Asynchronous reset mid-stream returns all outputs to reset values immediately. A key must be reloaded afterward.

## Test plan
- Encrypt: load key "lemon" (11,4,12,14,13), mode=0, out_ready=1, stream "attackatdawn" (0,19,19,0,2,10,0,19,3,0,22,13).
  - Expect 11,23,5,14,15,21,4,5,17,13,7,17, one per cycle, 1-cycle latency.
- Decrypt: same key, msg_start, mode=1, stream 11,23,5,14,15,21,4,5,17,13,7,17.
  - Expect 0,19,19,0,2,10,0,19,3,0,22,13.
- Spaces/invalid: key "ab" (0,1), encrypt 1,32,1,40,1.
  - Expect 1,32,2,32,1: spaces and invalid codes do not advance idx.
- Backpressure: hold out_ready=0 for 3 cycles after the first output.
  - Expect out_char stable, in_ready=0 while full, no drop or duplication.
  - Release out_ready: streaming resumes.
- Key edge cases:
  - Load 7 letters → key_len=6; the 7th is ignored.
  - key_done with none loaded → NOKEY, key_ok=0, in_ready=0.
  - Non-letter key_char is not stored.
- Reset/rekey mid-operation:
  - Assert resetn=0 with out_valid=1 → out_valid=0, key_len=0, state NOKEY immediately.
  - key_load in RUN with a pending output → output discarded, LOAD entered.
